// File: rtl/ysyx_23060025_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_axi_sram
//   AXI4 single-beat responder backing a word-addressed SRAM. Read and write
//   channels run independently, each with a fixed response latency.
//
// Ports
//   clock / reset           : rising-edge clock, asynchronous active-high reset
//   axi_addr_w_*            : AW channel (addr, valid, ready, id, len)
//   axi_w_*                 : W channel (data, strb, valid, ready, last)
//   axi_bkwd_*              : B channel (resp, valid, ready, id)
//   axi_addr_r_*            : AR channel (addr, valid, ready, id, len)
//   axi_r_*                 : R channel (data, resp, valid, ready, last, id)
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | counting down the read latency, array sampled at count zero
//   R_RESP | rvalid high, holding the response until rready
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W in any order
//   W_WAIT | counting down the write latency, array written at count zero
//   W_RESP | bvalid high, holding the response until bready
// ---------------------------------------------------------------------------
module ysyx_23060025_axi_sram #(
  parameter int          ADDR_LEN   = 32,
  parameter int          DATA_LEN   = 32,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          R_LAT      = 2,
  parameter int          W_LAT      = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] axi_addr_w_addr_i,
  input  logic                axi_addr_w_valid_i,
  output logic                axi_addr_w_ready_o,
  input  logic [3:0]          axi_addr_w_id_i,
  input  logic [7:0]          axi_addr_w_len_i,
  input  logic [DATA_LEN-1:0] axi_w_data_i,
  input  logic [3:0]          axi_w_strb_i,
  input  logic                axi_w_valid_i,
  output logic                axi_w_ready_o,
  input  logic                axi_w_last_i,
  output logic [1:0]          axi_bkwd_resp_o,
  output logic                axi_bkwd_valid_o,
  input  logic                axi_bkwd_ready_i,
  output logic [3:0]          axi_bkwd_id_o,
  input  logic [ADDR_LEN-1:0] axi_addr_r_addr_i,
  input  logic                axi_addr_r_valid_i,
  output logic                axi_addr_r_ready_o,
  input  logic [3:0]          axi_addr_r_id_i,
  input  logic [7:0]          axi_addr_r_len_i,
  output logic [DATA_LEN-1:0] axi_r_data_o,
  output logic [1:0]          axi_r_resp_o,
  output logic                axi_r_valid_o,
  input  logic                axi_r_ready_i,
  output logic                axi_r_last_o,
  output logic [3:0]          axi_r_id_o
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [DATA_LEN-1:0] r_mem [DEPTH];

  // ---------------- address decode ----------------
  // Offset above the shifted-out word range must be zero; the unsigned
  // compare against BASE rejects addresses below the window.
  logic [ADDR_LEN-1:0] w_ar_off;
  logic [ADDR_LEN-1:0] w_aw_off;
  logic                w_ar_in;
  logic                w_aw_in;

  assign w_ar_off = axi_addr_r_addr_i - ADDR_LEN'(BASE);
  assign w_aw_off = axi_addr_w_addr_i - ADDR_LEN'(BASE);
  assign w_ar_in  = (axi_addr_r_addr_i >= ADDR_LEN'(BASE)) &&
                    ((w_ar_off >> (DEPTH_LOG2 + 2)) == '0);
  assign w_aw_in  = (axi_addr_w_addr_i >= ADDR_LEN'(BASE)) &&
                    ((w_aw_off >> (DEPTH_LOG2 + 2)) == '0);

  // ---------------- read channel ----------------
  r_state_t              r_rstate;
  r_state_t              w_rstate_n;
  logic                  r_arready;
  logic [3:0]            r_rcnt;
  logic [3:0]            r_ar_id;
  logic [DEPTH_LOG2-1:0] r_ar_idx;
  logic [1:0]            r_ar_resp;
  logic                  r_rvalid;
  logic [DATA_LEN-1:0]   r_rdata;
  logic [1:0]            r_rresp;
  logic [3:0]            r_rid;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_r_sample;
  logic [1:0]            w_ar_resp;

  assign w_ar_hs   = r_arready & axi_addr_r_valid_i;
  assign w_r_hs    = r_rvalid & axi_r_ready_i;
  assign w_ar_resp = !w_ar_in                    ? RESP_DECERR :
                     (axi_addr_r_len_i != 8'd0)  ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_rstate_n = r_rstate;
    w_r_sample = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_n = R_WAIT;
      R_WAIT: if (r_rcnt == 4'd0) begin
        w_rstate_n = R_RESP;
        w_r_sample = 1'b1;
      end
      R_RESP: if (w_r_hs) w_rstate_n = R_IDLE;
      default: w_rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rcnt    <= 4'd0;
      r_ar_id   <= 4'd0;
      r_ar_idx  <= '0;
      r_ar_resp <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= 4'd0;
    end else begin
      r_rstate  <= w_rstate_n;
      r_arready <= (w_rstate_n == R_IDLE);
      if (w_ar_hs) begin
        r_ar_id   <= axi_addr_r_id_i;
        r_ar_idx  <= w_ar_off[DEPTH_LOG2+1:2];
        r_ar_resp <= w_ar_resp;
        r_rcnt    <= 4'(R_LAT);
      end else if (r_rstate == R_WAIT && r_rcnt != 4'd0) begin
        r_rcnt <= r_rcnt - 4'd1;
      end
      if (w_r_sample) begin
        r_rvalid <= 1'b1;
        r_rdata  <= (r_ar_resp == RESP_OKAY) ? r_mem[r_ar_idx] : '0;
        r_rresp  <= r_ar_resp;
        r_rid    <= r_ar_id;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi_addr_r_ready_o = r_arready;
  assign axi_r_valid_o      = r_rvalid;
  assign axi_r_last_o       = r_rvalid;
  assign axi_r_data_o       = r_rdata;
  assign axi_r_resp_o       = r_rresp;
  assign axi_r_id_o         = r_rid;

  // ---------------- write channel ----------------
  w_state_t              r_wstate;
  w_state_t              w_wstate_n;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic [3:0]            r_wcnt;
  logic [3:0]            r_aw_id;
  logic [DEPTH_LOG2-1:0] r_aw_idx;
  logic                  r_aw_dec;
  logic                  r_aw_len_err;
  logic [DATA_LEN-1:0]   r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_w_last_err;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [3:0]            r_bid;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic                  w_commit;
  logic [1:0]            w_wresp;

  assign w_aw_hs   = r_awready & axi_addr_w_valid_i;
  assign w_w_hs    = r_wready & axi_w_valid_i;
  assign w_b_hs    = r_bvalid & axi_bkwd_ready_i;
  // Captured already, or being captured at this edge.
  assign w_aw_have = r_aw_got | w_aw_hs;
  assign w_w_have  = r_w_got | w_w_hs;
  assign w_wresp   = r_aw_dec                      ? RESP_DECERR :
                     (r_aw_len_err | r_w_last_err) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_wstate_n = r_wstate;
    w_commit   = 1'b0;
    case (r_wstate)
      W_IDLE: if (w_aw_have && w_w_have) w_wstate_n = W_WAIT;
      W_WAIT: if (r_wcnt == 4'd0) begin
        w_wstate_n = W_RESP;
        w_commit   = 1'b1;
      end
      W_RESP: if (w_b_hs) w_wstate_n = W_IDLE;
      default: w_wstate_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wstate     <= W_IDLE;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_aw_got     <= 1'b0;
      r_w_got      <= 1'b0;
      r_wcnt       <= 4'd0;
      r_aw_id      <= 4'd0;
      r_aw_idx     <= '0;
      r_aw_dec     <= 1'b0;
      r_aw_len_err <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= 4'd0;
      r_w_last_err <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_bid        <= 4'd0;
    end else begin
      r_wstate  <= w_wstate_n;
      // Each ready stays up in W_IDLE until its own beat has been taken.
      r_awready <= (w_wstate_n == W_IDLE) && !(r_wstate == W_IDLE && w_aw_have);
      r_wready  <= (w_wstate_n == W_IDLE) && !(r_wstate == W_IDLE && w_w_have);
      if (w_aw_hs) begin
        r_aw_got     <= 1'b1;
        r_aw_id      <= axi_addr_w_id_i;
        r_aw_idx     <= w_aw_off[DEPTH_LOG2+1:2];
        r_aw_dec     <= !w_aw_in;
        r_aw_len_err <= (axi_addr_w_len_i != 8'd0);
      end else if (w_b_hs) begin
        r_aw_got <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_got      <= 1'b1;
        r_wdata      <= axi_w_data_i;
        r_wstrb      <= axi_w_strb_i;
        r_w_last_err <= !axi_w_last_i;
      end else if (w_b_hs) begin
        r_w_got <= 1'b0;
      end
      if (r_wstate == W_IDLE && w_wstate_n == W_WAIT) begin
        r_wcnt <= 4'(W_LAT);
      end else if (r_wstate == W_WAIT && r_wcnt != 4'd0) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wresp;
        r_bid    <= r_aw_id;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Array write lands at the edge, so a read sampled at the same edge
  // observes the old word.
  always_ff @(posedge clock) begin
    if (w_commit && w_wresp == RESP_OKAY) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign axi_addr_w_ready_o = r_awready;
  assign axi_w_ready_o      = r_wready;
  assign axi_bkwd_valid_o   = r_bvalid;
  assign axi_bkwd_resp_o    = r_bresp;
  assign axi_bkwd_id_o      = r_bid;

endmodule

// File: tb/tb_ysyx_23060025_axi_sram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_axi_sram
//   Directed scenarios plus a randomized mix of reads and writes, checked
//   against a word-array model of the SRAM and the address/len/last rules.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_axi_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          R_LAT = 2;
  localparam int          W_LAT = 2;

  logic        clock;
  logic        reset;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_id;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic        r_last;
  logic [3:0]  r_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mdl   [4096];
  bit          known [4096];

  ysyx_23060025_axi_sram #(
    .ADDR_LEN(32), .DATA_LEN(32), .BASE(BASE), .DEPTH_LOG2(12),
    .R_LAT(R_LAT), .W_LAT(W_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .axi_addr_w_addr_i(aw_addr), .axi_addr_w_valid_i(aw_valid),
    .axi_addr_w_ready_o(aw_ready), .axi_addr_w_id_i(aw_id),
    .axi_addr_w_len_i(aw_len),
    .axi_w_data_i(w_data), .axi_w_strb_i(w_strb), .axi_w_valid_i(w_valid),
    .axi_w_ready_o(w_ready), .axi_w_last_i(w_last),
    .axi_bkwd_resp_o(b_resp), .axi_bkwd_valid_o(b_valid),
    .axi_bkwd_ready_i(b_ready), .axi_bkwd_id_o(b_id),
    .axi_addr_r_addr_i(ar_addr), .axi_addr_r_valid_i(ar_valid),
    .axi_addr_r_ready_o(ar_ready), .axi_addr_r_id_i(ar_id),
    .axi_addr_r_len_i(ar_len),
    .axi_r_data_o(r_data), .axi_r_resp_o(r_resp), .axi_r_valid_o(r_valid),
    .axi_r_ready_i(r_ready), .axi_r_last_o(r_last), .axi_r_id_o(r_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len,
                                          input logic last);
    if (addr < BASE || addr >= BASE + 32'h4000) return 2'b11;
    if (len != 8'd0 || !last) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off[11:0]);
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input int hold, output logic [31:0] data, output logic [1:0] resp);
    int n;
    int t0;
    ar_addr = addr; ar_id = id; ar_len = len; ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin @(posedge clock); #1; n++; end
    if (n >= 50) chk("ar_ready_timeout", 0, 1);
    @(posedge clock); #1;
    t0 = cyc;
    ar_valid = 1'b0;
    chk("ar_ready_drop", {31'd0, ar_ready}, 0);
    n = 0;
    while (!r_valid && n < 60) begin @(posedge clock); #1; n++; end
    if (n >= 60) chk("r_valid_timeout", 0, 1);
    chk("r_latency", 32'(cyc - t0), 32'(R_LAT + 1));
    data = r_data;
    resp = r_resp;
    chk("r_id", {28'd0, r_id}, {28'd0, id});
    chk("r_last", {31'd0, r_last}, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("r_hold_valid", {31'd0, r_valid}, 1);
      chk("r_hold_data", r_data, data);
      chk("r_hold_id", {28'd0, r_id}, {28'd0, id});
      chk("r_hold_resp", {30'd0, r_resp}, {30'd0, resp});
    end
    r_ready = 1'b1;
    @(posedge clock); #1;
    r_ready = 1'b0;
    chk("r_valid_drop", {31'd0, r_valid}, 0);
    chk("ar_ready_back", {31'd0, ar_ready}, 1);
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] id, input logic [7:0] len, input logic last,
                          input int lead, output logic [1:0] resp, output logic [3:0] bid);
    int  aw_start;
    int  w_start;
    int  c;
    int  n;
    int  tb0;
    bit  aw_done;
    bit  w_done;
    bit  aw_fire;
    bit  w_fire;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 60) begin
      if (c == aw_start) begin
        aw_addr = addr; aw_id = id; aw_len = len; aw_valid = 1'b1;
      end
      if (c == w_start) begin
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
      end
      aw_fire = aw_valid && aw_ready;
      w_fire  = w_valid && w_ready;
      @(posedge clock); #1;
      c++;
      if (aw_fire) begin aw_valid = 1'b0; aw_done = 1; end
      if (w_fire)  begin w_valid  = 1'b0; w_done  = 1; end
      if (aw_fire && !w_done) begin
        chk("aw_ready_own_drop", {31'd0, aw_ready}, 0);
        chk("w_ready_held", {31'd0, w_ready}, 1);
      end
      if (w_fire && !aw_done) begin
        chk("w_ready_own_drop", {31'd0, w_ready}, 0);
        chk("aw_ready_held", {31'd0, aw_ready}, 1);
      end
    end
    if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
    tb0 = cyc;
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 60) begin @(posedge clock); #1; n++; end
    if (n >= 60) chk("b_valid_timeout", 0, 1);
    chk("b_latency", 32'(cyc - tb0), 32'(W_LAT + 1));
    resp = b_resp;
    bid  = b_id;
    @(posedge clock); #1;
    b_ready = 1'b0;
    chk("b_valid_drop", {31'd0, b_valid}, 0);
    chk("aw_ready_back", {31'd0, aw_ready}, 1);
    chk("w_ready_back", {31'd0, w_ready}, 1);
  endtask

  task automatic wr_chk(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [3:0] id, input logic [7:0] len, input logic last,
                        input int lead);
    logic [1:0] resp;
    logic [3:0] bid;
    logic [1:0] er;
    int         k;
    do_write(addr, data, strb, id, len, last, lead, resp, bid);
    er = exp_resp(addr, len, last);
    chk("b_resp", {30'd0, resp}, {30'd0, er});
    chk("b_id", {28'd0, bid}, {28'd0, id});
    if (er == 2'b00) begin
      k = widx(addr);
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[k][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input int hold, output logic [31:0] data);
    logic [1:0]  resp;
    logic [1:0]  er;
    logic [31:0] ed;
    do_read(addr, id, len, hold, data, resp);
    er = exp_resp(addr, len, 1'b1);
    ed = (er == 2'b00) ? mdl[widx(addr)] : 32'd0;
    chk("r_resp", {30'd0, resp}, {30'd0, er});
    chk("r_data", data, ed);
  endtask

  task automatic full_write(input int k, input logic [31:0] v);
    wr_chk(BASE + 32'(k * 4), v, 4'hF, 4'h1, 8'd0, 1'b1, 0);
    known[k] = 1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [7:0]  ln;
    logic        lst;
    int          op;
    int          k;

    reset = 1'b1;
    aw_addr = 0; aw_valid = 0; aw_id = 0; aw_len = 0;
    w_data = 0; w_strb = 0; w_valid = 0; w_last = 0; b_ready = 0;
    ar_addr = 0; ar_valid = 0; ar_id = 0; ar_len = 0; r_ready = 0;

    #12;
    chk("rst_arready", {31'd0, ar_ready}, 0);
    chk("rst_awready", {31'd0, aw_ready}, 0);
    chk("rst_wready", {31'd0, w_ready}, 0);
    chk("rst_bvalid", {31'd0, b_valid}, 0);
    chk("rst_rvalid", {31'd0, r_valid}, 0);
    chk("rst_rlast", {31'd0, r_last}, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_ids", {24'd0, r_id, b_id}, 0);
    chk("rst_resps", {28'd0, r_resp, b_resp}, 0);
    #10;
    reset = 1'b0;
    #1;
    chk("rel_arready_low", {31'd0, ar_ready}, 0);
    @(posedge clock); #1;
    chk("rel_arready", {31'd0, ar_ready}, 1);
    chk("rel_awready", {31'd0, aw_ready}, 1);
    chk("rel_wready", {31'd0, w_ready}, 1);

    // Full write then readback.
    wr_chk(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3, 8'd0, 1'b1, 0);
    known[4] = 1;
    rd_chk(32'h8000_0010, 4'h7, 8'd0, 0, d);
    chk("readback_const", d, 32'hDEAD_BEEF);

    // Partial strobe merge.
    wr_chk(32'h8000_0010, 32'h1122_3344, 4'b0101, 4'h2, 8'd0, 1'b1, 0);
    rd_chk(32'h8000_0010, 4'h1, 8'd0, 0, d);
    chk("partial_const", d, 32'hDE22_BE44);

    // W three cycles ahead of AW, then AW ahead of W.
    wr_chk(32'h8000_0014, 32'hCAFE_0001, 4'hF, 4'h5, 8'd0, 1'b1, 3);
    known[5] = 1;
    wr_chk(32'h8000_0018, 32'hCAFE_0002, 4'hF, 4'h6, 8'd0, 1'b1, -2);
    known[6] = 1;
    rd_chk(32'h8000_0014, 4'h5, 8'd0, 0, d);
    rd_chk(32'h8000_0018, 4'h6, 8'd0, 0, d);

    // Error responses: out of range, wrap alias of index 0, bad len/last.
    full_write(0, 32'h0BAD_F00D);
    rd_chk(32'h7FFF_FFFC, 4'h9, 8'd0, 0, d);
    wr_chk(BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 4'hA, 8'd0, 1'b1, 0);
    rd_chk(BASE, 4'h2, 8'd0, 0, d);
    chk("idx0_unchanged", d, 32'h0BAD_F00D);
    rd_chk(BASE, 4'h3, 8'd3, 0, d);
    wr_chk(BASE, 32'h1234_5678, 4'hF, 4'h4, 8'd1, 1'b1, 0);
    wr_chk(BASE, 32'h1234_5678, 4'hF, 4'h4, 8'd0, 1'b0, 1);
    wr_chk(BASE + 32'h4000, 32'h1, 4'hF, 4'h4, 8'd2, 1'b1, 0);
    wr_chk(BASE + 32'h4, 32'h5555_AAAA, 4'h0, 4'h8, 8'd0, 1'b1, 0);
    rd_chk(BASE, 4'h3, 8'd0, 0, d);

    // R stalled while a write runs to completion.
    fork
      rd_chk(32'h8000_0010, 4'h9, 8'd0, 5, d);
      wr_chk(32'h8000_0020, 32'h7777_8888, 4'hF, 4'hC, 8'd0, 1'b1, 0);
    join
    known[8] = 1;
    rd_chk(32'h8000_0020, 4'hD, 8'd0, 0, d);

    // Reset while the read is counting down.
    ar_addr = 32'h8000_0010; ar_id = 4'h2; ar_len = 0; ar_valid = 1'b1;
    @(posedge clock); #1;
    ar_valid = 1'b0;
    @(posedge clock); #1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", {31'd0, r_valid}, 0);
    chk("mid_rst_arready", {31'd0, ar_ready}, 0);
    chk("mid_rst_rdata", r_data, 0);
    @(posedge clock); @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("mid_rel_arready_low", {31'd0, ar_ready}, 0);
    @(posedge clock); #1;
    chk("mid_rel_arready", {31'd0, ar_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      chk("no_stale_r", {31'd0, r_valid}, 0);
      @(posedge clock); #1;
    end
    rd_chk(32'h8000_0010, 4'h4, 8'd0, 0, d);

    // Randomized traffic over a small working set.
    for (int i = 0; i < 16; i++) if (!known[i]) full_write(i, $urandom);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      k  = $urandom_range(0, 15);
      a  = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      if (op <= 1) begin
        wr_chk(a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               8'd0, 1'b1, $urandom_range(0, 6) - 3);
      end else if (op <= 3) begin
        rd_chk(a, 4'($urandom_range(0, 15)), 8'd0, 0, d);
      end else begin
        case ($urandom_range(0, 2))
          0: a = BASE + 32'h4000 + 32'($urandom_range(0, 255) * 4);
          1: a = BASE - 32'($urandom_range(1, 256) * 4);
          default: ;
        endcase
        ln  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        lst = ($urandom_range(0, 1) != 0);
        if ($urandom_range(0, 1) != 0)
          wr_chk(a, $urandom, 4'hF, 4'($urandom_range(0, 15)), ln, lst,
                 $urandom_range(0, 6) - 3);
        else
          rd_chk(a, 4'($urandom_range(0, 15)), ln, 0, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_23060025_axi_sram.md
Name: ysyx_23060025_axi_sram
Overview: AXI4 single-beat slave (responder) backing a word-addressed SRAM array. It sits behind the Xbar on the SOC path, opposite the core's AXI master controller. Read and write channels are independent, with programmable response latency.
Parameters:
ADDR_LEN, 32, address width
DATA_LEN, 32, data width; the data path is fixed at 32-bit, 4 strobes
BASE, 32'h8000_0000, first byte address mapped
DEPTH_LOG2, 12, log2 of word count (4096 words, 16 KiB)
R_LAT / W_LAT, 2 / 2, extra wait cycles before R / B, each in 0..15
Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
axi_addr_w_addr_i  in  ADDR_LEN  write address
axi_addr_w_valid_i  in  1  AW valid
axi_addr_w_ready_o  out  1  AW ready
axi_addr_w_id_i  in  4  write ID
axi_addr_w_len_i  in  8  burst length; only 0 is legal
axi_w_data_i  in  DATA_LEN  write data
axi_w_strb_i  in  4  byte strobes
axi_w_valid_i  in  1  W valid
axi_w_ready_o  out  1  W ready
axi_w_last_i  in  1  last beat; must be 1
axi_bkwd_resp_o  out  2  write response
axi_bkwd_valid_o  out  1  B valid
axi_bkwd_ready_i  in  1  B ready
axi_bkwd_id_o  out  4  echoed AW ID
axi_addr_r_addr_i  in  ADDR_LEN  read address
axi_addr_r_valid_i  in  1  AR valid
axi_addr_r_ready_o  out  1  AR ready
axi_addr_r_id_i  in  4  read ID
axi_addr_r_len_i  in  8  burst length; only 0 is legal
axi_r_data_o  out  DATA_LEN  read data
axi_r_resp_o  out  2  read response
axi_r_valid_o  out  1  R valid
axi_r_ready_i  in  1  R ready
axi_r_last_o  out  1  equals axi_r_valid_o
axi_r_id_o  out  4  echoed AR ID
Behaviour:
- Reset (asynchronous, any time, including mid-transaction): both FSMs go to IDLE, all counters clear, in-flight transactions are dropped without a response. Every output is 0 (readies, valids, resp, data, id, last). SRAM contents are not cleared. Readies are registered and rise on the first clock edge after reset deasserts.
- Word index is (addr - BASE) >> 2. Address bits [1:0] are ignored.
- In range: BASE <= addr < BASE + 4·2^DEPTH_LOG2. Otherwise resp = DECERR 2'b11.
- len != 0, or last == 0 on W: resp = SLVERR 2'b10. DECERR takes priority over SLVERR.
- Any error response causes no SRAM write and returns read data 0. OKAY is 2'b00.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready = 1. On AR handshake at edge T, latch id, index and error; arready drops after T. Go to R_WAIT with cnt = R_LAT.
  - R_WAIT: decrement cnt each cycle. At cnt == 0, sample the array, go to R_RESP, and assert rvalid (first valid cycle T+1+R_LAT).
  - R_RESP: hold data, resp, id and valid stable until rready. On handshake, return to R_IDLE; arready is 1 on the next cycle. There is no back-to-back AR acceptance, so minimum read spacing is 3+R_LAT cycles.
- Write FSM states: W_IDLE, W_WAIT, W_RESP. AW and W are accepted independently, in either order or in the same cycle.
  - awready stays high until AW is captured; wready stays high until W is captured. Each drops after its own handshake.
  - Once both are captured, load cnt = W_LAT and enter W_WAIT.
  - When W_WAIT reaches cnt == 0, commit the write: bytes with strb[i] = 1 update byte i, others are unchanged; strb = 0 is a legal no-op. Go to W_RESP with bvalid = 1 and hold until bready. After the B handshake, awready and wready return high.
- Same-cycle commit and read sample to the same word: the read returns pre-write data, because the array write takes effect at the edge.
- Holding rready or bready low stalls only that channel; the other channel continues.
Test Plan:
- BASE=8000_0000, R_LAT=2. Write word 0x0000_0010 = 0xDEADBEEF with strb 4'hF, then read it -> bvalid with resp 00; AR handshake at T, rvalid at T+3, data 0xDEADBEEF, rlast 1, resp 00, id echoed.
- Partial write 0x11223344 with strb 4'b0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
- W presented 3 cycles before AW, id 4'h5 -> single B with id 5, resp 00; each ready drops only after its own handshake.
- Read at 0x7FFF_FFFC, then a write at BASE+0x4000 -> read returns resp 11 with data 0; B resp 11 and a readback of index 0 is unchanged. ar len = 3 -> resp 10.
- Hold rready low 5 cycles with rvalid up while a write completes -> data, id and resp stay stable; B completes independently.
- Assert reset during R_WAIT -> rvalid stays 0 and no stale R after release; arready high on the first edge after release.
